// File: rtl/imem_loader.sv
// Boot-time instruction memory front end: assembles a length-prefixed big-endian
// byte stream into instruction RAM, holds the core in reset until loaded, then serves IR.
module imem_loader #(
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic          reload,
   input  logic [31:0]   IR_addr,
   output logic [31:0]   IR,
   output logic          core_rst_n,
   output logic          loaded,
   output logic          err,
   output logic [AW:0]   word_cnt
);

   localparam int unsigned DEPTH = 1 << AW;

   localparam logic [2:0] HDR_HI = 3'd0;
   localparam logic [2:0] HDR_LO = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] RUN    = 3'd3;
   localparam logic [2:0] ERR    = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [15:0]      len;
   logic [1:0]       byte_idx;
   logic [23:0]      asm_buf;
   logic [31:0]      mem [DEPTH];
   logic [DEPTH-1:0] word_vld;

   logic             accept;
   logic [15:0]      hdr_len;
   logic [AW:0]      wc_inc;
   logic             word_done;
   logic [AW-1:0]    rd_idx;
   logic             addr_lsb_unused;

   // Handshake and shared decode
   always_comb begin
      in_ready  = (state == HDR_HI) || (state == HDR_LO) || (state == LOAD);
      accept    = in_valid && in_ready;
      hdr_len   = {len[15:8], in_data};
      wc_inc    = word_cnt + (AW + 1)'(1);
      word_done = accept && (state == LOAD) && (byte_idx == 2'd3);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= HDR_HI;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HDR_HI: if (accept) state_nxt = HDR_LO;
         HDR_LO: begin
            if (accept) begin
               if (hdr_len > 16'(DEPTH))  state_nxt = ERR;
               else if (hdr_len == 16'd0) state_nxt = RUN;
               else                       state_nxt = LOAD;
            end
         end
         LOAD:    if (word_done && (16'(wc_inc) == len)) state_nxt = RUN;
         RUN:     if (reload) state_nxt = HDR_HI;
         ERR:     state_nxt = ERR;
         default: state_nxt = HDR_HI;
      endcase
   end

   // Counters, header capture, status flags; core reset releases one edge after RUN entry
   always_ff @(posedge clk) begin
      if (rst) begin
         len        <= '0;
         byte_idx   <= '0;
         asm_buf    <= '0;
         word_cnt   <= '0;
         word_vld   <= '0;
         core_rst_n <= 1'b0;
         loaded     <= 1'b0;
         err        <= 1'b0;
      end else begin
         core_rst_n <= (state == RUN) && (state_nxt == RUN);
         loaded     <= (state_nxt == RUN);
         err        <= (state_nxt == ERR);
         case (state)
            HDR_HI: if (accept) len[15:8] <= in_data;
            HDR_LO: if (accept && (state_nxt == LOAD)) len <= hdr_len;
            LOAD: begin
               if (accept) begin
                  asm_buf  <= {asm_buf[15:0], in_data};
                  byte_idx <= byte_idx + 2'd1;
               end
               if (word_done) begin
                  word_cnt                   <= wc_inc;
                  word_vld[word_cnt[AW-1:0]] <= 1'b1;
               end
            end
            RUN: begin
               if (reload) begin
                  word_cnt <= '0;
                  byte_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Cleared words are modelled by word_vld, so the array itself needs no reset
   always_ff @(posedge clk) begin
      if (!rst && word_done) mem[word_cnt[AW-1:0]] <= {asm_buf, in_data};
   end

   always_comb begin
      IR              = 32'h0;
      rd_idx          = IR_addr[AW+1:2];
      addr_lsb_unused = ^IR_addr[1:0];
      if ((IR_addr[31:AW+2] == '0) && word_vld[rd_idx]) IR = mem[rd_idx];
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_imem_loader;

   localparam int unsigned AW = 8;

   localparam int K_IR   = 0;
   localparam int K_RDY  = 1;
   localparam int K_LD   = 2;
   localparam int K_CRST = 3;
   localparam int K_ERR  = 4;
   localparam int K_WC   = 5;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] val;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          reload;
   logic [31:0]   IR_addr;
   logic [31:0]   IR;
   logic          core_rst_n;
   logic          loaded;
   logic          err;
   logic [AW:0]   word_cnt;

   exp_t       exp_q[$];
   logic [7:0] stream_q[$];
   int         vectors     = 0;
   int         miscompares = 0;

   imem_loader #(.AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .reload     (reload),
      .IR_addr    (IR_addr),
      .IR         (IR),
      .core_rst_n (core_rst_n),
      .loaded     (loaded),
      .err        (err),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] observe(input int k);
      case (k)
         K_IR:    return IR;
         K_RDY:   return {31'b0, in_ready};
         K_LD:    return {31'b0, loaded};
         K_CRST:  return {31'b0, core_rst_n};
         K_ERR:   return {31'b0, err};
         K_WC:    return 32'(word_cnt);
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Monitor: drain pending expectations on the falling edge
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e   = exp_q.pop_front();
         act = observe(e.kind);
         vectors++;
         if (act !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic expect_val(input string nm, input int k, input logic [31:0] v);
      exp_t e;
      e.name = nm;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_ir(input string nm, input logic [31:0] addr, input logic [31:0] v);
      IR_addr = addr;
      expect_val(nm, K_IR, v);
      settle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
   endtask

   // Send stream_q; gapped inserts one idle cycle after every accepted byte
   task automatic send_stream(input bit gapped);
      foreach (stream_q[i]) begin
         int n;
         in_data  = stream_q[i];
         in_valid = 1'b1;
         n = 0;
         while (!in_ready && n < 20) begin
            tick();
            n++;
         end
         if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: byte %0d never accepted", i);
         end
         tick();
         if (gapped) begin
            in_valid = 1'b0;
            tick();
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;
      IR_addr  = 32'h0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      expect_val("rst_in_ready", K_RDY, 32'd1);
      expect_val("rst_loaded", K_LD, 32'd0);
      expect_val("rst_core_rst_n", K_CRST, 32'd0);
      expect_val("rst_err", K_ERR, 32'd0);
      expect_val("rst_word_cnt", K_WC, 32'd0);
      expect_val("rst_ir0", K_IR, 32'h0);
      settle();

      // Basic load with in_valid held high
      stream_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      send_stream(1'b0);
      expect_val("basic_in_ready", K_RDY, 32'd0);
      expect_val("basic_loaded", K_LD, 32'd1);
      expect_val("basic_word_cnt", K_WC, 32'd2);
      expect_val("basic_core_rst_early", K_CRST, 32'd0);
      settle();
      tick();
      expect_val("basic_core_rst_n", K_CRST, 32'd1);
      settle();
      read_ir("basic_ir0", 32'h0, 32'h2008_0005);
      read_ir("basic_ir4", 32'h4, 32'hAC08_0000);
      read_ir("basic_ir8", 32'h8, 32'h0);

      // Reload with a shorter program; stale word 1 survives
      pulse_reload();
      expect_val("reload_core_rst_n", K_CRST, 32'd0);
      expect_val("reload_loaded", K_LD, 32'd0);
      expect_val("reload_word_cnt", K_WC, 32'd0);
      expect_val("reload_in_ready", K_RDY, 32'd1);
      settle();
      stream_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      send_stream(1'b0);
      expect_val("reload_done_loaded", K_LD, 32'd1);
      expect_val("reload_done_wc", K_WC, 32'd1);
      settle();
      read_ir("reload_ir0", 32'h0, 32'h0);
      read_ir("reload_ir4_stale", 32'h4, 32'hAC08_0000);

      // Reset mid-word discards everything, including earlier RAM contents
      pulse_reload();
      stream_q = '{8'h00, 8'h02, 8'h20, 8'h08};
      send_stream(1'b0);
      do_reset();
      expect_val("midrst_in_ready", K_RDY, 32'd1);
      expect_val("midrst_word_cnt", K_WC, 32'd0);
      expect_val("midrst_loaded", K_LD, 32'd0);
      settle();
      read_ir("midrst_ir0", 32'h0, 32'h0);
      read_ir("midrst_ir4", 32'h4, 32'h0);
      read_ir("midrst_ir3fc", 32'h3FC, 32'h0);

      // Gapped full load, with an idle stretch mid-stream
      stream_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
      send_stream(1'b1);
      expect_val("gap_wc_mid", K_WC, 32'd1);
      expect_val("gap_ready_mid", K_RDY, 32'd1);
      settle();
      tick();
      tick();
      expect_val("gap_wc_idle", K_WC, 32'd1);
      expect_val("gap_loaded_idle", K_LD, 32'd0);
      settle();
      stream_q = '{8'hAC, 8'h08, 8'h00, 8'h00};
      send_stream(1'b1);
      expect_val("gap_word_cnt", K_WC, 32'd2);
      expect_val("gap_loaded", K_LD, 32'd1);
      expect_val("gap_core_rst_n", K_CRST, 32'd1);
      settle();
      read_ir("gap_ir0", 32'h0, 32'h2008_0005);
      read_ir("gap_ir4", 32'h4, 32'hAC08_0000);
      read_ir("gap_ir3_lsb_ignored", 32'h3, 32'h2008_0005);
      read_ir("gap_ir400_oob", 32'h400, 32'h0);

      // Simultaneous rst and reload: rst wins and RAM is cleared
      rst    = 1'b1;
      reload = 1'b1;
      tick();
      rst    = 1'b0;
      reload = 1'b0;
      expect_val("rstrl_in_ready", K_RDY, 32'd1);
      expect_val("rstrl_loaded", K_LD, 32'd0);
      settle();
      read_ir("rstrl_ir4", 32'h4, 32'h0);

      // Zero-length program
      stream_q = '{8'h00, 8'h00};
      send_stream(1'b0);
      expect_val("zero_loaded", K_LD, 32'd1);
      expect_val("zero_word_cnt", K_WC, 32'd0);
      expect_val("zero_in_ready", K_RDY, 32'd0);
      expect_val("zero_core_rst_early", K_CRST, 32'd0);
      settle();
      tick();
      expect_val("zero_core_rst_n", K_CRST, 32'd1);
      settle();
      read_ir("zero_ir0", 32'h0, 32'h0);

      // Length exactly equal to depth is accepted
      do_reset();
      stream_q = '{8'h01, 8'h00};
      send_stream(1'b0);
      expect_val("len256_err", K_ERR, 32'd0);
      expect_val("len256_in_ready", K_RDY, 32'd1);
      expect_val("len256_loaded", K_LD, 32'd0);
      settle();

      // Overflow: sticky error, reload ignored
      do_reset();
      stream_q = '{8'h01, 8'h01};
      send_stream(1'b0);
      expect_val("ovf_err", K_ERR, 32'd1);
      expect_val("ovf_in_ready", K_RDY, 32'd0);
      expect_val("ovf_core_rst_n", K_CRST, 32'd0);
      settle();
      for (int i = 0; i < 20; i++) begin
         reload = (i % 2 == 0);
         tick();
         expect_val("ovf_hold_err", K_ERR, 32'd1);
         expect_val("ovf_hold_ready", K_RDY, 32'd0);
         expect_val("ovf_hold_core_rst_n", K_CRST, 32'd0);
         settle();
      end
      reload = 1'b0;
      do_reset();
      expect_val("ovf_rst_err", K_ERR, 32'd0);
      expect_val("ovf_rst_ready", K_RDY, 32'd1);
      settle();

      settle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
